// File: rtl/bcd_share_sched_pkg.sv
// +----------------------------------------------------------------------+
// | bcd_sched_pkg: shared types, widths and the binary->BCD helper.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_sched_pkg;

  localparam int VAL_W = 8;
  localparam int BCD_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 8-bit value to {HUNDREDS[1:0], TENS[3:0], ONES[3:0]}; hundreds never exceeds 2.
  function automatic logic [BCD_W-1:0] bin2bcd(input logic [VAL_W-1:0] v);
    logic [1:0] h;
    logic [6:0] r;
    logic [3:0] t;
    logic [3:0] o;
    h = (v >= 8'd200) ? 2'd2 : ((v >= 8'd100) ? 2'd1 : 2'd0);
    r = 7'(v - 8'(h) * 8'd100);
    t = 4'(r / 7'd10);
    o = 4'(r % 7'd10);
    return {h, t, o};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_share_sched_if.sv
// +----------------------------------------------------------------------+
// | bcd_share_sched_if: request/value/result bundle of the BCD scheduler.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface bcd_share_sched_if #(
  parameter int N_SRC = 4
);
  import bcd_sched_pkg::*;

  logic [N_SRC-1:0]       req;
  logic [VAL_W*N_SRC-1:0] val;
  logic                   busy;
  logic [N_SRC-1:0]       ack;
  logic [BCD_W*N_SRC-1:0] bcd_out;
  logic [N_SRC-1:0]       ovf;

  modport master (output req, val, input busy, ack, bcd_out, ovf);
  modport slave  (input req, val, output busy, ack, bcd_out, ovf);

endinterface

`default_nettype wire

// File: rtl/bcd_share_sched_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick: first set pending index searching from ptr, wrapping.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     pend,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest set bit is assigned last.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (pend[idx]) begin
        gnt = IDX_W'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_share_sched.sv
// +----------------------------------------------------------------------+
// | bcd_share_sched: round-robin sharing of one binary->BCD converter.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_share_sched
  import bcd_sched_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int MAX_VAL = 99
) (
  input  logic              clk,
  input  logic              rst,
  bcd_share_sched_if.slave  bus
);

  localparam int                IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [VAL_W-1:0]  MAX_V = VAL_W'(MAX_VAL);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_SRC - 1);

  state_t                 state;
  logic [N_SRC-1:0]       pend;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       gnt;
  logic [VAL_W-1:0]       hold;
  logic [BCD_W*N_SRC-1:0] bcd_q;
  logic [N_SRC-1:0]       ovf_q;

  logic [IDX_W-1:0]       pick_gnt;
  logic                   pick_any;
  logic [N_SRC-1:0]       done_mask;
  logic [BCD_W-1:0]       conv;

  rr_pick #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .pend (pend),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  assign conv      = bin2bcd(hold);
  assign done_mask = (state == ST_DONE) ? (N_SRC'(1) << gnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pend  <= '0;
      ptr   <= '0;
      gnt   <= '0;
      hold  <= '0;
      bcd_q <= '0;
      ovf_q <= '0;
    end else begin
      // A request arriving in the DONE cycle re-arms the slot being retired.
      pend <= (pend & ~done_mask) | bus.req;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt   <= pick_gnt;
            hold  <= bus.val[pick_gnt*VAL_W +: VAL_W];
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          bcd_q[gnt*BCD_W +: BCD_W] <= conv;
          ovf_q[gnt]                <= (hold > MAX_V);
          state                     <= ST_DONE;
        end
        ST_DONE: begin
          ptr   <= (gnt == LAST) ? '0 : gnt + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.ack     = done_mask;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_share_sched.sv
// Scoreboard bench for bcd_share_sched: stimulus queues expected results,
// a negedge monitor retires them on each ACK.
`default_nettype none

module tb_bcd_share_sched;

  typedef struct {
    int         src;
    logic [9:0] bcd;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  bcd_share_sched_if #(.N_SRC(4)) bus ();

  bcd_share_sched #(
    .N_SRC   (4),
    .MAX_VAL (99)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int src, input logic [9:0] bcd, input logic ovf);
    exp_t e;
    e.src = src;
    e.bcd = bcd;
    e.ovf = ovf;
    q.push_back(e);
  endtask

  task automatic drain();
    int idle_cnt;
    idle_cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.busy) idle_cnt++;
      else idle_cnt = 0;
      if (idle_cnt == 2) break;
    end
    chk("drain_timeout", 64'(idle_cnt), 64'd2);
    tick();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.ack != 4'b0) begin
      exp_t e;
      int   idx;
      idx = -1;
      for (int i = 0; i < 4; i++) if (bus.ack[i]) idx = i;
      chk("ack_onehot", 64'($countones(bus.ack)), 64'd1);
      if (q.size() == 0) begin
        chk("unexpected_ack", 64'(bus.ack), 64'd0);
      end else begin
        e = q.pop_front();
        chk("ack_src", 64'(idx), 64'(e.src));
        chk("slot_bcd", 64'(bus.bcd_out[10*e.src +: 10]), 64'(e.bcd));
        chk("slot_ovf", 64'(bus.ovf[e.src]), 64'(e.ovf));
      end
    end
  end

  initial begin
    bus.req = 4'h0;
    bus.val = '0;

    // 1: reset with requests asserted
    rst     = 1'b1;
    bus.req = 4'hF;
    repeat (3) tick();
    rst     = 1'b0;
    bus.req = 4'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_ack", 64'(bus.ack), 64'd0);
      chk("rst_bcd", 64'(bus.bcd_out), 64'd0);
    end
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    tick();

    // 2: single conversion with latency probes
    bus.val[7:0] = 8'd59;
    bus.req      = 4'b0001;
    push(0, 10'h059, 1'b0);
    tick();
    bus.req = 4'b0000;
    @(negedge clk);
    chk("lat_c1_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("lat_c2_busy", 64'(bus.busy), 64'd1);
    chk("lat_c2_slot0", 64'(bus.bcd_out[9:0]), 64'd0);
    @(negedge clk);
    chk("lat_c3_ack", 64'(bus.ack), 64'b0001);
    @(negedge clk);
    chk("lat_c4_busy", 64'(bus.busy), 64'd0);
    drain();

    // 3: round robin from a fresh pointer
    rst = 1'b1;
    repeat (2) tick();
    rst     = 1'b0;
    bus.val = {8'd23, 8'd45, 8'd59, 8'd7};
    bus.req = 4'hF;
    push(0, 10'h007, 1'b0);
    push(1, 10'h059, 1'b0);
    push(2, 10'h045, 1'b0);
    push(3, 10'h023, 1'b0);
    tick();
    bus.req = 4'h0;
    drain();
    bus.req = 4'b1001;
    push(0, 10'h007, 1'b0);
    push(3, 10'h023, 1'b0);
    tick();
    bus.req = 4'h0;
    drain();

    // 4: re-request during DONE, value change mid-conversion, src2 slips in
    bus.val[15:8] = 8'd12;
    bus.req       = 4'b0010;
    push(1, 10'h012, 1'b0);
    tick();
    tick();
    bus.val[15:8] = 8'd34;
    bus.req       = 4'b0110;
    push(2, 10'h045, 1'b0);
    push(1, 10'h034, 1'b0);
    tick();
    bus.req = 4'b0010;
    tick();
    tick();
    bus.req = 4'b0000;
    drain();

    // 5: overflow and range bounds
    bus.val[23:16] = 8'd255;
    bus.req        = 4'b0100;
    push(2, 10'h255, 1'b1);
    tick();
    bus.req = 4'h0;
    drain();
    bus.val[23:16] = 8'd99;
    bus.req        = 4'b0100;
    push(2, 10'h099, 1'b0);
    tick();
    bus.req = 4'h0;
    drain();
    bus.val[23:16] = 8'd0;
    bus.req        = 4'b0100;
    push(2, 10'h000, 1'b0);
    tick();
    bus.req = 4'h0;
    drain();
    chk("all_slots", 64'(bus.bcd_out), 64'({10'h023, 10'h000, 10'h034, 10'h007}));
    chk("all_ovf", 64'(bus.ovf), 64'd0);

    // 6: reset during CONV
    bus.val[7:0] = 8'd59;
    bus.req      = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    @(negedge clk);
    chk("mid_conv_busy", 64'(bus.busy), 64'd1);
    #4;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_bcd", 64'(bus.bcd_out), 64'd0);
    chk("mid_rst_ovf", 64'(bus.ovf), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mid_rst_idle", 64'({bus.busy, bus.ack}), 64'd0);
    end

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
